// File: rtl/m216a_top_module.sv
// MASH 1-1-1 delta-sigma modulator: 4-bit integer + 16-bit fraction in, 4-bit
// noise-shaped integer stream out, for driving a multi-modulus divider.
module m216a_top_module (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_i,
    input  logic [15:0] in_f,
    output logic [3:0]  out
);

    logic [15:0] acc1, acc2, acc3;
    logic        c1, c2, c3;
    logic        c1_d, c1_dd, c2_d, c2_dd, c3_d, c3_dd;
    logic [3:0]  in_i_d, in_i_dd, in_i_ddd;
    logic [16:0] sum1, sum2, sum3;
    logic signed [5:0] corr, total;
    logic [3:0]  out_nxt;

    assign sum1 = {1'b0, acc1} + {1'b0, in_f};
    assign sum2 = {1'b0, acc2} + {1'b0, acc1};
    assign sum3 = {1'b0, acc3} + {1'b0, acc2};

    // Noise cancellation: stage-1/2 carry noise cancels, leaving -(1-z^-1)^3 E3.
    always_comb begin
        corr = 6'(c1_dd) + 6'(c2_d) - 6'(c2_dd)
             + 6'(c3) - 6'({c3_d, 1'b0}) + 6'(c3_dd);
        total = corr + $signed({2'b00, in_i_ddd});
        if (total < 6'sd0)
            out_nxt = 4'd0;
        else if (total > 6'sd15)
            out_nxt = 4'd15;
        else
            out_nxt = total[3:0];
    end

    // rst_n is active-high despite its name; the port name is kept for compatibility.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc1 <= '0; acc2 <= '0; acc3 <= '0;
            c1 <= 1'b0; c2 <= 1'b0; c3 <= 1'b0;
            c1_d <= 1'b0; c1_dd <= 1'b0;
            c2_d <= 1'b0; c2_dd <= 1'b0;
            c3_d <= 1'b0; c3_dd <= 1'b0;
            in_i_d <= '0; in_i_dd <= '0; in_i_ddd <= '0;
            out <= '0;
        end else begin
            {c1, acc1} <= sum1;
            {c2, acc2} <= sum2;
            {c3, acc3} <= sum3;
            c1_d <= c1; c1_dd <= c1_d;
            c2_d <= c2; c2_dd <= c2_d;
            c3_d <= c3; c3_dd <= c3_d;
            in_i_d <= in_i; in_i_dd <= in_i_d; in_i_ddd <= in_i_dd;
            out <= out_nxt;
        end
    end

endmodule

// File: tb/tb_m216a_top_module.sv
// Randomized scoreboard bench for the MASH 1-1-1 modulator: a history-based
// reference model predicts every output sample, plus mean and range checks.
module tb_m216a_top_module;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_i;
    logic [15:0] in_f;
    logic [3:0]  out;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    bit done = 1'b0;

    m216a_top_module dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in_i (in_i),
        .in_f (in_f),
        .out  (out)
    );

    always #5 clk = ~clk;

    // Reference model: carry and input histories indexed by cycle number since
    // reset (offset by 3 so cycles -3..-1 read as zero).  Output at cycle n is
    // in_i[n-3] + c1[n-3] + (c2[n-2]-c2[n-3]) + (c3[n-1]-2c3[n-2]+c3[n-3]), clamped.
    localparam int HN = 16384;
    int ch1 [HN];
    int ch2 [HN];
    int ch3 [HN];
    int ih  [HN];

    initial begin
        int n, a1, a2, a3, s1, s2, s3, v;
        n = 0; a1 = 0; a2 = 0; a3 = 0;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                n = 0; a1 = 0; a2 = 0; a3 = 0;
                for (int k = 0; k < 4; k++) begin
                    ch1[k] = 0; ch2[k] = 0; ch3[k] = 0; ih[k] = 0;
                end
                v = 0;
            end else begin
                n++;
                s1 = a1 + int'(in_f);
                s2 = a2 + a1;
                s3 = a3 + a2;
                ch1[n+3] = s1 / 65536;
                ch2[n+3] = s2 / 65536;
                ch3[n+3] = s3 / 65536;
                a1 = s1 % 65536; a2 = s2 % 65536; a3 = s3 % 65536;
                ih[n+3] = int'(in_i);
                v = ih[n] + ch1[n] + (ch2[n+1] - ch2[n])
                  + (ch3[n+2] - 2 * ch3[n+1] + ch3[n]);
                if (v < 0) v = 0;
                if (v > 15) v = 15;
            end
            exp_q.push_back(v);
        end
    end

    // Monitor: one expected sample per clock edge, checked 1 time unit later.
    initial begin
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0 && !done) begin
                e = exp_q.pop_front();
                n_vec++;
                if (int'(out) != e) begin
                    n_err++;
                    $display("FAIL out_sample t=%0t in_i=%0d in_f=%0d got=%0d exp=%0d",
                             $time, in_i, in_f, out, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b1;
        cyc(n);
        rst_n = 1'b0;
    endtask

    // Sample out on falling edges; return sum and extremes.
    task automatic collect(input int n, output int sum, output int mn, output int mx);
        sum = 0; mn = 99; mx = -1;
        repeat (n) begin
            @(negedge clk);
            sum += int'(out);
            if (int'(out) < mn) mn = int'(out);
            if (int'(out) > mx) mx = int'(out);
        end
    endtask

    task automatic check(input string name, input bit ok, input real got, input string req);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s got=%f required %s", name, got, req);
        end
    endtask

    initial begin
        int sum, mn, mx;
        real mean;
        rst_n = 1'b1; in_i = 4'd9; in_f = 16'd1234;
        cyc(5);
        check("reset_out_zero", out == 4'd0, real'(out), "0");

        // Integer only
        rst_n = 1'b0; in_i = 4'd8; in_f = 16'd0;
        cyc(3);
        collect(30, sum, mn, mx);
        check("int_only_min", mn == 8, real'(mn), "8");
        check("int_only_max", mx == 8, real'(mx), "8");

        // Half fraction
        in_f = 16'd32768;
        cyc(10);
        collect(2000, sum, mn, mx);
        mean = real'(sum) / 2000.0;
        check("half_mean", mean > 8.495 && mean < 8.505, mean, "8.500+-0.005");
        check("half_min", mn >= 5, real'(mn), ">=5");
        check("half_max", mx <= 12, real'(mx), "<=12");

        // Main vector from fresh reset
        do_reset(1);
        in_i = 4'd8; in_f = 16'd32000;
        cyc(10);
        collect(2000, sum, mn, mx);
        mean = real'(sum) / 2000.0;
        check("main_mean", mean > 8.48 && mean < 8.50, mean, "(8.48,8.50)");

        // Reset mid-run
        do_reset(1);
        cyc(500);
        do_reset(1);
        check("midrun_reset_zero", out == 4'd0, real'(out), "0");
        cyc(60);

        // Saturation high and low
        in_i = 4'd15; in_f = 16'd60000;
        cyc(5);
        collect(300, sum, mn, mx);
        check("sat_hi_max", mx <= 15, real'(mx), "<=15");
        check("sat_hi_nowrap", mn >= 12, real'(mn), ">=12");
        in_i = 4'd0; in_f = 16'd100;
        cyc(5);
        collect(300, sum, mn, mx);
        check("sat_lo_nowrap", mx <= 4, real'(mx), "<=4");

        // Random segments, occasional reset
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 4) == 0) do_reset($urandom_range(1, 3));
            in_i = 4'($urandom_range(0, 15));
            in_f = 16'($urandom);
            cyc($urandom_range(20, 80));
        end

        cyc(2);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
